// File: rtl/host_uart_rx_pkg.sv
// host_uart_rx_pkg: shared UART definitions (FSM encoding, baud-divider helpers, defaults)
package host_uart_rx_pkg;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_cycles(input int clk_hz, input int baud);
        return bit_cycles(clk_hz, baud) / 2;
    endfunction
endpackage

// File: rtl/host_uart_rx_if.sv
// host_uart_rx_if: valid/ready byte stream out of the UART receiver
interface host_uart_rx_if #(parameter int DATA_BITS = host_uart_rx_pkg::DEF_DATA_BITS);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master(output m_data, m_valid, input m_ready);
    modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/host_uart_rx_sync_2ff.sv
// host_uart_rx_sync_2ff: two-flop synchroniser with selectable reset value
module host_uart_rx_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= {2{RST_VAL}};
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/host_uart_rx.sv
// host_uart_rx: 8N1 UART receiver, mid-bit sampling, one-byte valid/ready output buffer
module host_uart_rx
    import host_uart_rx_pkg::*;
#(
    parameter int CLK_HZ    = 125_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    host_uart_rx_if.master m,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);
    localparam int BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
    localparam int HALF_CYCLES = half_cycles(CLK_HZ, BAUD);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    if (BIT_CYCLES < 4) begin : g_baud_chk
        $error("host_uart_rx: BIT_CYCLES must be at least 4");
    end

    state_t               state, state_nx;
    logic                 rx_s, tick, stop_ok, stop_bad, deliver, take;
    logic [1:0]           primed;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;

    host_uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    assign tick = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else state <= state_nx;
    end

    // The synchroniser's reset value is not a real look at the line, so WAIT_IDLE
    // only trusts rx_s once both stages hold sampled data.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_IDLE: state_nx = rx_s && primed[1] ? IDLE : WAIT_IDLE;
            IDLE:      state_nx = rx_s ? IDLE : START;
            START:     state_nx = !tick ? START : rx_s ? IDLE : DATA;
            DATA:      state_nx = tick && idx == LAST_IDX ? STOP : DATA;
            STOP:      state_nx = !tick ? STOP : rx_s ? IDLE : WAIT_IDLE;
            default:   state_nx = WAIT_IDLE;
        endcase
    end

    always_comb begin
        busy     = state inside {START, DATA, STOP};
        stop_ok  = state == STOP && tick && rx_s;
        stop_bad = state == STOP && tick && !rx_s;
        take     = deliver && (!m.m_valid || m.m_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed    <= '0;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            m.m_data  <= '0;
            m.m_valid <= 1'b0;
        end else begin
            primed    <= {primed[0], 1'b1};
            cnt       <= state == IDLE ? HALF_LOAD : tick ? BIT_LOAD : cnt - 1'b1;
            idx       <= state == START ? '0 : state == DATA && tick ? idx + 1'b1 : idx;
            if (state == DATA && tick) shreg[idx] <= rx_s;
            deliver   <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= deliver && !take;
            m.m_valid <= take || (m.m_valid && !m.m_ready);
            if (take) m.m_data <= shreg;
        end
    end
endmodule
